mem_bank_streamer: RTL and testbench

MEM_BANK_STREAMER -- requirements
Module: mem_bank_streamer

---
 rtl/fpga_mem_pkg.sv | 18 +
 rtl/sync_fifo.sv | 57 +++++
 rtl/mem_bank_streamer.sv | 204 ++++++++++++++++++++
 tb/tb_mem_bank_streamer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_mem_pkg.sv
// Shared types and limits for the on-chip memory bank streamer.
package fpga_mem_pkg;

    // Deepest bank read pipeline the streamer is built to track.
    localparam int RD_LATENCY_MAX = 4;

    // Width of FIFO occupancy and in-flight counters; covers RD_LATENCY_MAX+1.
    localparam int CNT_W = $clog2(RD_LATENCY_MAX + 2);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO holding returned bank read words until the
// downstream reader accepts them. Depth need not be a power of two.
module sync_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 256,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty  = (count == '0);
    assign do_pop = pop && !empty;
    assign head   = store[rd_ptr];

    // Data storage carries no reset; validity lives in the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            store[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CNT_W'(push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/mem_bank_streamer.sv
// Burst streamer between a command/data stream interface and a set of
// on-chip memory banks. Writes pass straight through to the selected bank;
// reads are issued against a credit scheme so returned words always fit
// in the local FIFO even when the reader stalls.
module mem_bank_streamer
    import fpga_mem_pkg::*;
#(
    parameter int NUM_BANKS  = 3,
    parameter int DATA_W     = 256,
    parameter int ADDR_W     = 11,
    parameter int LEN_W      = 8,
    parameter int RD_LATENCY = 2
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset_n,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [1:0]                    cmd_bank,
    input  logic [ADDR_W-1:0]             cmd_addr,
    input  logic [LEN_W-1:0]              cmd_len,
    input  logic [DATA_W/8-1:0]           cmd_be,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          done,
    output logic                          err,
    output logic [NUM_BANKS*ADDR_W-1:0]   mem_address,
    output logic [NUM_BANKS-1:0]          mem_chipselect,
    output logic [NUM_BANKS-1:0]          mem_clken,
    output logic [NUM_BANKS-1:0]          mem_write,
    output logic [NUM_BANKS*DATA_W-1:0]   mem_writedata,
    output logic [NUM_BANKS*DATA_W/8-1:0] mem_byteenable,
    input  logic [NUM_BANKS*DATA_W-1:0]   mem_readdata
);

    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = RD_LATENCY + 1;

    state_t               state;
    logic                 run;
    logic                 done_q;
    logic [1:0]           bank_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [LEN_W:0]       beats_left;
    logic [BE_W-1:0]      be_q;
    logic [RD_LATENCY-1:0] rd_vld_p;
    logic [CNT_W-1:0]     inflight;

    logic                 wr_beat;
    logic                 issue;
    logic                 push;
    logic                 pop;
    logic                 last_beat;
    logic                 drain_last;
    logic [DATA_W-1:0]    sel_rdata;
    logic [DATA_W-1:0]    fifo_head;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;

    // run stays low through reset so every output reads 0 until the first edge after release.
    assign cmd_ready  = run && (state == ST_IDLE);
    assign wr_ready   = (state == ST_WRITE);
    assign err        = (state == ST_ERR);
    assign mem_clken  = {NUM_BANKS{run}};

    assign wr_beat    = (state == ST_WRITE) && wr_valid;
    assign last_beat  = (beats_left == (LEN_W+1)'(1));
    // Credit check: FIFO occupancy plus reads still in the bank pipeline must leave a free slot.
    assign issue      = (state == ST_READ) &&
                        (({1'b0, fifo_count} + {1'b0, inflight}) < (CNT_W+1)'(DEPTH));
    assign push       = rd_vld_p[RD_LATENCY-1];
    assign pop        = rd_ready && !fifo_empty;
    assign drain_last = (state == ST_DRAIN) && (inflight == '0) &&
                        (fifo_count == CNT_W'(1)) && pop;

    assign rd_valid   = !fifo_empty;
    assign rd_data    = fifo_empty ? '0 : fifo_head;
    assign done       = done_q || drain_last;

    // Drive only the selected bank, and only in a cycle that carries an access.
    always_comb begin
        mem_chipselect = '0;
        mem_write      = '0;
        mem_address    = '0;
        mem_writedata  = '0;
        mem_byteenable = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if ((wr_beat || issue) && (bank_q == 2'(b))) begin
                mem_chipselect[b]                  = 1'b1;
                mem_write[b]                       = wr_beat;
                mem_address[b*ADDR_W +: ADDR_W]    = addr_q;
                mem_writedata[b*DATA_W +: DATA_W]  = wr_beat ? wr_data : '0;
                mem_byteenable[b*BE_W +: BE_W]     = wr_beat ? be_q : {BE_W{1'b1}};
            end
        end
    end

    // Pick the latched bank's read return for the FIFO.
    always_comb begin
        sel_rdata = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (bank_q == 2'(b)) begin
                sel_rdata = mem_readdata[b*DATA_W +: DATA_W];
            end
        end
    end

    // Command latch, burst counting and state sequencing.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state      <= ST_IDLE;
            run        <= 1'b0;
            done_q     <= 1'b0;
            bank_q     <= '0;
            addr_q     <= '0;
            beats_left <= '0;
            be_q       <= '0;
        end else begin
            run    <= 1'b1;
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        bank_q     <= cmd_bank;
                        addr_q     <= cmd_addr;
                        beats_left <= {1'b0, cmd_len} + (LEN_W+1)'(1);
                        be_q       <= cmd_be;
                        if (int'(cmd_bank) >= NUM_BANKS) begin
                            state <= ST_ERR;
                        end else if (cmd_write) begin
                            state <= ST_WRITE;
                        end else begin
                            state <= ST_READ;
                        end
                    end
                end
                ST_WRITE: begin
                    if (wr_beat) begin
                        addr_q     <= addr_q + ADDR_W'(1);
                        beats_left <= beats_left - (LEN_W+1)'(1);
                        if (last_beat) begin
                            state  <= ST_IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        addr_q     <= addr_q + ADDR_W'(1);
                        beats_left <= beats_left - (LEN_W+1)'(1);
                        if (last_beat) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_last) begin
                        state <= ST_IDLE;
                    end
                end
                ST_ERR: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Reads in flight: one valid bit per bank pipeline stage plus a running count.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rd_vld_p <= '0;
            inflight <= '0;
        end else begin
            rd_vld_p[0] <= issue;
            for (int i = 1; i < RD_LATENCY; i++) begin
                rd_vld_p[i] <= rd_vld_p[i-1];
            end
            inflight <= inflight + CNT_W'(issue) - CNT_W'(push);
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk_clk),
        .rst_n     (reset_reset_n),
        .push      (push),
        .push_data (sel_rdata),
        .pop       (pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_mem_bank_streamer.sv
// Directed bench for mem_bank_streamer with a behavioural bank model.
module tb_mem_bank_streamer;

    localparam int NB = 3;
    localparam int DW = 256;
    localparam int AW = 11;
    localparam int LW = 8;
    localparam int RL = 2;
    localparam int BW = DW / 8;

    logic               clk_clk;
    logic               reset_reset_n;
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_write;
    logic [1:0]         cmd_bank;
    logic [AW-1:0]      cmd_addr;
    logic [LW-1:0]      cmd_len;
    logic [BW-1:0]      cmd_be;
    logic               wr_valid;
    logic               wr_ready;
    logic [DW-1:0]      wr_data;
    logic               rd_valid;
    logic               rd_ready;
    logic [DW-1:0]      rd_data;
    logic               done;
    logic               err;
    logic [NB*AW-1:0]   mem_address;
    logic [NB-1:0]      mem_chipselect;
    logic [NB-1:0]      mem_clken;
    logic [NB-1:0]      mem_write;
    logic [NB*DW-1:0]   mem_writedata;
    logic [NB*BW-1:0]   mem_byteenable;
    logic [NB*DW-1:0]   mem_readdata;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] bmem  [NB][2048];
    logic [DW-1:0] rpipe [NB][RL];
    logic [AW-1:0] wr_addr_log [8];

    mem_bank_streamer #(
        .NUM_BANKS  (NB),
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .LEN_W      (LW),
        .RD_LATENCY (RL)
    ) dut (
        .clk_clk        (clk_clk),
        .reset_reset_n  (reset_reset_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_write      (cmd_write),
        .cmd_bank       (cmd_bank),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .cmd_be         (cmd_be),
        .wr_valid       (wr_valid),
        .wr_ready       (wr_ready),
        .wr_data        (wr_data),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .rd_data        (rd_data),
        .done           (done),
        .err            (err),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_clken      (mem_clken),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_byteenable (mem_byteenable),
        .mem_readdata   (mem_readdata)
    );

    initial clk_clk = 1'b0;
    always #5 clk_clk = ~clk_clk;

    function automatic logic [DW-1:0] pat(input int b, input int a);
        logic [31:0] w;
        w = 32'hC0DE_0000 | (32'(b) << 12) | 32'(a);
        return {8{w}};
    endfunction

    function automatic logic [DW-1:0] wdat(input int i);
        logic [31:0] w;
        w = 32'hD00D_0000 + 32'(i);
        return {8{w}};
    endfunction

    // Bank model: byte-masked writes, reads returned RL cycles after issue.
    always @(posedge clk_clk) begin
        for (int b = 0; b < NB; b++) begin
            for (int s = RL - 1; s > 0; s--) rpipe[b][s] <= rpipe[b][s-1];
            if (mem_chipselect[b] && !mem_write[b])
                rpipe[b][0] <= bmem[b][mem_address[b*AW +: AW]];
            if (mem_chipselect[b] && mem_write[b]) begin
                for (int j = 0; j < BW; j++)
                    if (mem_byteenable[b*BW + j])
                        bmem[b][mem_address[b*AW +: AW]][j*8 +: 8] = mem_writedata[b*DW + j*8 +: 8];
            end
        end
    end

    for (genvar g = 0; g < NB; g++) begin : g_rd
        assign mem_readdata[g*DW +: DW] = rpipe[g][RL-1];
    end

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_ctl"}, {cmd_ready, wr_ready, rd_valid, done, err}, 0);
        check_val({tag, "_rdata"}, rd_data, 0);
        check_val({tag, "_addr"}, mem_address, 0);
        check_val({tag, "_cs_we_clken"}, {mem_chipselect, mem_write, mem_clken}, 0);
        check_val({tag, "_be"}, mem_byteenable, 0);
        check_val({tag, "_wdata"}, |mem_writedata, 0);
    endtask

    task automatic send_cmd(input logic wr, input int bank, input int addr, input int len, input logic [BW-1:0] be);
        int t;
        @(negedge clk_clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_bank  = 2'(bank);
        cmd_addr  = AW'(addr);
        cmd_len   = LW'(len);
        cmd_be    = be;
        t = 0;
        while (!cmd_ready && t < 20) begin
            @(negedge clk_clk);
            t++;
        end
        check_val("cmd_ready", cmd_ready, 1);
        @(posedge clk_clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic do_write(input int bank, input int addr, input int len, input logic [BW-1:0] be);
        send_cmd(1'b1, bank, addr, len, be);
        for (int i = 0; i <= len; i++) begin
            wr_valid = 1'b1;
            wr_data  = wdat(i);
            @(negedge clk_clk);
            check_val("wr_ready", wr_ready, 1);
            check_val("wr_cs", mem_chipselect, 1 << bank);
            check_val("wr_we", mem_write, 1 << bank);
            check_val("wr_be", mem_byteenable[bank*BW +: BW], be);
            check_val("wr_data", mem_writedata[bank*DW +: DW], wdat(i));
            check_val("wr_early_done", done, 0);
            wr_addr_log[i] = mem_address[bank*AW +: AW];
            @(posedge clk_clk);
            #1;
        end
        wr_valid = 1'b0;
        wr_data  = '0;
        @(negedge clk_clk);
        check_val("wr_done", done, 1);
        check_val("wr_idle_cs", mem_chipselect, 0);
        check_val("wr_idle_ready", cmd_ready, 1);
        @(negedge clk_clk);
        check_val("wr_done_pulse", done, 0);
    endtask

    // hold > 0 keeps rd_ready low for that many cycles after the handshake.
    task automatic do_read(input int bank, input int addr, input int len, input int hold, input logic chk_lat);
        int n, got, cs_cnt, done_cnt, first;
        logic [NB-1:0] other_cs;
        n = 0; got = 0; cs_cnt = 0; done_cnt = 0; first = -1; other_cs = '0;
        rd_ready = (hold == 0);
        send_cmd(1'b0, bank, addr, len, '1);
        while (got <= len && n < 200) begin
            @(negedge clk_clk);
            if (hold > 0 && n == hold) begin
                check_val("stall_cs_count", cs_cnt, 3);
                check_val("stall_rd_valid", rd_valid, 1);
                rd_ready = 1'b1;
                #1;
            end
            if (mem_chipselect[bank]) cs_cnt++;
            other_cs |= mem_chipselect & ~(NB'(1) << bank);
            if (done) done_cnt++;
            if (rd_valid && rd_ready) begin
                if (first < 0) first = n;
                check_val($sformatf("rd_data%0d", got), rd_data, pat(bank, (addr + got) % 2048));
                check_val($sformatf("rd_done%0d", got), done, (got == len));
                got++;
            end
            n++;
        end
        check_val("rd_word_count", got, len + 1);
        check_val("rd_issue_count", cs_cnt, len + 1);
        check_val("rd_done_count", done_cnt, 1);
        check_val("rd_other_cs", other_cs, 0);
        if (chk_lat) check_val("rd_first_latency", first, 3);
        @(negedge clk_clk);
        check_val("rd_no_dup", rd_valid, 0);
        check_val("rd_back_idle", cmd_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] exp_a [4];
        int issued;

        for (int b = 0; b < NB; b++)
            for (int a = 0; a < 2048; a++)
                bmem[b][a] = pat(b, a);

        reset_reset_n = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_bank = '0; cmd_addr = '0;
        cmd_len = '0; cmd_be = '0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
        #1 reset_reset_n = 1'b0;
        #1 check_all_zero("por");
        repeat (3) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        @(negedge clk_clk);
        check_val("post_rst_ready", cmd_ready, 1);
        check_val("post_rst_clken", mem_clken, 3'b111);

        // Read burst with reader always ready.
        do_read(1, 'h010, 3, 0, 1'b1);

        // Masked write burst into bank 1.
        do_write(1, 'h010, 3, 32'hFFFF_0000);
        exp_a = '{11'h010, 11'h011, 11'h012, 11'h013};
        for (int i = 0; i < 4; i++) check_val($sformatf("wr_addr%0d", i), wr_addr_log[i], exp_a[i]);

        // Reader stalled: issue must stop at the FIFO depth.
        do_read(2, 'h100, 7, 20, 1'b0);

        // Address wrap at the top of the bank.
        do_write(0, 'h7FE, 3, 32'hFFFF_FFFF);
        exp_a = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};
        for (int i = 0; i < 4; i++) check_val($sformatf("wrap_addr%0d", i), wr_addr_log[i], exp_a[i]);

        // Out-of-range bank.
        send_cmd(1'b0, 3, 'h000, 0, '1);
        @(negedge clk_clk);
        check_val("err_pulse", err, 1);
        check_val("err_busy", cmd_ready, 0);
        check_val("err_cs", mem_chipselect, 0);
        check_val("err_no_done", done, 0);
        @(negedge clk_clk);
        check_val("err_clear", err, 0);
        check_val("err_ready", cmd_ready, 1);
        check_val("err_cs2", mem_chipselect, 0);
        check_val("err_no_done2", done, 0);

        // Reset in the middle of a read burst.
        rd_ready = 1'b1;
        send_cmd(1'b0, 1, 'h020, 7, '1);
        issued = 0;
        for (int t = 0; t < 20 && issued < 3; t++) begin
            @(negedge clk_clk);
            if (mem_chipselect[1]) issued++;
        end
        check_val("rst_reached_beat", issued, 3);
        reset_reset_n = 1'b0;
        #1 check_all_zero("rst_mid");
        @(posedge clk_clk);
        @(negedge clk_clk);
        check_all_zero("rst_hold");
        reset_reset_n = 1'b1;
        @(negedge clk_clk);
        check_val("rst_rel_ready", cmd_ready, 1);
        check_val("rst_rel_no_done", done, 0);
        check_val("rst_rel_no_valid", rd_valid, 0);
        do_read(1, 'h020, 7, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
